// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with KMP fallback, selectable overlap and a saturating match counter.
// Optional SEQ_DET_REG_OUT_EN: when defined, match is registered (one cycle later); otherwise it is Mealy.
module seq_detector_param #(
    parameter int unsigned PAT_LEN = 4,
    parameter logic [31:0] PATTERN = 32'h0000000A,
    parameter bit          OVERLAP = 1'b0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             clear_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [5:0]       state_dbg
);

    localparam int unsigned SW    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int unsigned TBL_N = 2 ** (SW + 1);

    if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
        $error("seq_detector_param: PAT_LEN must be in 2..32");
    end

    // Pattern bit i in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(int unsigned i);
        logic [31:0] sh;
        sh = PATTERN >> (PAT_LEN - 1 - i);
        return sh[0];
    endfunction

    // Longest proper pattern prefix that is a suffix of (prefix_k followed by b).
    function automatic int unsigned longest_prefix(int unsigned k, logic b);
        int unsigned best;
        logic        ok;
        logic        s;
        best = 0;
        for (int unsigned l = 1; l < PAT_LEN; l++) begin
            if (l <= k + 1) begin
                ok = 1'b1;
                for (int unsigned j = 0; j < l; j++) begin
                    s = ((k + 1 - l + j) == k) ? b : pat_bit(k + 1 - l + j);
                    if (s != pat_bit(j)) ok = 1'b0;
                end
                if (ok) best = l;
            end
        end
        return best;
    endfunction

    // Entry {k, bit} holds the next prefix length; padding entries stay 0.
    function automatic logic [TBL_N*SW-1:0] build_tbl();
        logic [TBL_N*SW-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < PAT_LEN; k++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                t[(2*k+b)*SW +: SW] = SW'(longest_prefix(k, 1'(b)));
            end
        end
        return t;
    endfunction

    localparam logic [TBL_N*SW-1:0] NEXT_TBL = build_tbl();
    localparam logic [SW-1:0]       LAST_K   = SW'(PAT_LEN - 1);
    localparam logic [SW-1:0]       BORDER   = SW'(longest_prefix(PAT_LEN - 1, PATTERN[0]));
    localparam logic [SW-1:0]       RESTART  = OVERLAP ? BORDER : '0;
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    logic [SW-1:0]    k;
    logic [SW:0]      tbl_idx;
    logic [SW-1:0]    tbl_next;
    logic             hit;
    logic [CNT_W-1:0] cnt;

    assign tbl_idx  = {k, in};
    assign tbl_next = NEXT_TBL[32'(tbl_idx)*SW +: SW];
    assign hit      = in_valid && (k == LAST_K) && (in == PATTERN[0]);

    // Prefix-length state; unreachable encodings fall back to empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (in_valid) begin
            if (hit)                     k <= RESTART;
            else if (32'(k) >= PAT_LEN)  k <= '0;
            else                         k <= tbl_next;
        end
    end

    // Saturating match counter; clear has priority over a same-cycle match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= '0;
        else if (clear_count)             cnt <= '0;
        else if (hit && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
    end

`ifdef SEQ_DET_REG_OUT_EN
    logic match_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) match_q <= 1'b0;
        else     match_q <= hit;
    end

    assign match = match_q;
`else
    assign match = hit;
`endif

    assign match_count = cnt;
    assign state_dbg   = 6'(k);

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param against a history-window reference model.
// Five instances with different parameters share the same input stream.
module tb_seq_detector_param;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic din = 1'b0;
    logic clear_count = 1'b0;

    logic [NI-1:0] m;
    logic [5:0]    sd [NI];
    logic [7:0]    c0, c1, c2;
    logic [1:0]    c3;
    logic [3:0]    c4;
    int            obs_cnt [NI];

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(32'hA), .OVERLAP(1'b0), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clear_count(clear_count),
        .match(m[0]), .match_count(c0), .state_dbg(sd[0]));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(32'hA), .OVERLAP(1'b1), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clear_count(clear_count),
        .match(m[1]), .match_count(c1), .state_dbg(sd[1]));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(32'hD), .OVERLAP(1'b0), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clear_count(clear_count),
        .match(m[2]), .match_count(c2), .state_dbg(sd[2]));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(32'hA), .OVERLAP(1'b1), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clear_count(clear_count),
        .match(m[3]), .match_count(c3), .state_dbg(sd[3]));
    seq_detector_param #(.PAT_LEN(3), .PATTERN(32'h7), .OVERLAP(1'b1), .CNT_W(4)) u_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .clear_count(clear_count),
        .match(m[4]), .match_count(c4), .state_dbg(sd[4]));

    always_comb begin
        obs_cnt[0] = 32'(c0);
        obs_cnt[1] = 32'(c1);
        obs_cnt[2] = 32'(c2);
        obs_cnt[3] = 32'(c3);
        obs_cnt[4] = 32'(c4);
    end

    // Reference parameters and model state.
    int p_len  [NI] = '{4, 4, 4, 4, 3};
    int p_pat  [NI] = '{10, 10, 13, 10, 7};
    bit p_ov   [NI] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int p_max  [NI] = '{255, 255, 255, 3, 15};
    bit hist   [NI][$];
    int cnt_m  [NI];
    bit prev_hit [NI];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit patbit(int i, int j);
        return bit'((p_pat[i] >> (p_len[i] - 1 - j)) & 1);
    endfunction

    // Longest pattern prefix shorter than the pattern that ends the history.
    function automatic int model_k(int i);
        int best = 0;
        int n = hist[i].size();
        for (int l = 1; l < p_len[i]; l++) begin
            if (l <= n) begin
                bit ok = 1'b1;
                for (int j = 0; j < l; j++)
                    if (hist[i][n-l+j] != patbit(i, j)) ok = 1'b0;
                if (ok) best = l;
            end
        end
        return best;
    endfunction

    function automatic bit window_match(int i);
        if (hist[i].size() != p_len[i]) return 1'b0;
        for (int j = 0; j < p_len[i]; j++)
            if (hist[i][j] != patbit(i, j)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input bit v, input bit b, input bit clr);
        @(negedge clk);
        in_valid = v;
        din = b;
        clear_count = clr;
        #1;
        for (int i = 0; i < NI; i++) begin
            int exp_k;
            bit hit;
            bit exp_m;
            exp_k = model_k(i);
            hit = 1'b0;
            if (v) begin
                hist[i].push_back(b);
                if (hist[i].size() > p_len[i]) void'(hist[i].pop_front());
                hit = window_match(i);
                if (hit && !p_ov[i]) hist[i].delete();
            end
`ifdef SEQ_DET_REG_OUT_EN
            exp_m = prev_hit[i];
`else
            exp_m = hit;
`endif
            check($sformatf("u%0d_match", i), int'(m[i]), int'(exp_m));
            check($sformatf("u%0d_k", i), int'(sd[i]), exp_k);
            check($sformatf("u%0d_cnt", i), obs_cnt[i], cnt_m[i]);
            prev_hit[i] = hit;
            if (clr) cnt_m[i] = 0;
            else if (hit && cnt_m[i] < p_max[i]) cnt_m[i]++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        clear_count = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            hist[i].delete();
            cnt_m[i] = 0;
            prev_hit[i] = 1'b0;
            check($sformatf("u%0d_rst_k", i), int'(sd[i]), 0);
            check($sformatf("u%0d_rst_cnt", i), obs_cnt[i], 0);
            check($sformatf("u%0d_rst_match", i), int'(m[i]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input bit b);
        step(1'b1, b, 1'b0);
    endtask

    initial begin
        int s1 [6] = '{1, 0, 1, 0, 1, 0};
        int s3 [5] = '{1, 1, 1, 0, 1};

        // Overlap vs non-overlap on 101010.
        do_reset();
        foreach (s1[j]) send(bit'(s1[j]));
        step(1'b0, 1'b0, 1'b0);
        check("a_cnt_101010", obs_cnt[0], 1);
        check("a_k_101010", int'(sd[0]), 2);
        check("b_cnt_101010", obs_cnt[1], 2);
        check("b_k_101010", int'(sd[1]), 2);

        // KMP fallback on 1101.
        do_reset();
        foreach (s3[j]) send(bit'(s3[j]));
        step(1'b0, 1'b0, 1'b0);
        check("c_cnt_11101", obs_cnt[2], 1);
        check("c_k_11101", int'(sd[2]), 0);

        // Stalls between bits keep the partial match.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            send(bit'(s1[j]));
            repeat (3) step(1'b0, 1'b1, 1'b0);
        end
        check("a_cnt_stall", obs_cnt[0], 1);

        // Saturation, then clear racing a match.
        do_reset();
        repeat (6) begin
            send(1'b1);
            send(1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        check("d_cnt_sat", obs_cnt[3], 3);
        send(1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("d_cnt_clr", obs_cnt[3], 0);
        check("d_k_clr", int'(sd[3]), 2);

        // Reset mid-pattern discards the prefix.
        do_reset();
        send(1'b1);
        send(1'b0);
        send(1'b1);
        do_reset();
        send(1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("a_cnt_midrst", obs_cnt[0], 0);
        check("a_k_midrst", int'(sd[0]), 0);

        // Random stream with stalls, clears and an occasional reset.
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom & 1),
                 bit'($urandom_range(0, 29) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
